regfile_wb_ctrl: RTL and testbench

- Write-back controller in front of the Elpis 32x32 register file's single write port.
- Arbitrates regfile writes between three requesters: ALU write-back, memory load return, and debug.
- Registers the winning write into the regfile write port.
- Keeps a pending-write scoreboard so the decode stage can detect RAW/WAW hazards on source and destination registers.

---
 rtl/regfile_wb_ctrl_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_wb_ctrl.sv | 121 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared definitions for the register-file write-back controller.
// Covers requester encoding and register-address geometry.
package regfile_wb_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_ALU  = 2'd2,
    SRC_DBG  = 2'd3
  } src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy vector with set/clear/flush and three combinational lookups.
// Latency: updates at the next edge, lookups same cycle; no backpressure.
module regfile_scoreboard
  import regfile_wb_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_vld,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_vld,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] chk_a,
  input  logic [REG_ADDR_W-1:0] chk_b,
  input  logic [REG_ADDR_W-1:0] chk_d,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_d
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;

  // Set is applied after clear so a fresh producer stays outstanding; flush beats both.
  always_comb begin
    busy_nxt = busy_q;
    if (clr_vld) busy_nxt[clr_addr] = 1'b0;
    if (set_vld) busy_nxt[set_addr] = 1'b1;
    if (flush)   busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_nxt;
  end

  assign busy_a = busy_q[chk_a];
  assign busy_b = busy_q[chk_b];
  assign busy_d = busy_q[chk_d];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Arbitrates MEM/ALU/DBG writes onto the single regfile write port and tracks pending writes.
// Latency: grant in cycle N drives rf_wrd in N+1; backpressure: one ready per cycle, losers hold.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  input  logic [DataWidth-1:0]  mem_data,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_addr,
  input  logic [DataWidth-1:0]  alu_data,
  input  logic                  dbg_valid,
  output logic                  dbg_ready,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  input  logic [DataWidth-1:0]  dbg_data,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] chk_a,
  input  logic [REG_ADDR_W-1:0] chk_b,
  input  logic [REG_ADDR_W-1:0] chk_d,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_d,
  output logic                  rf_wrd,
  output logic [REG_ADDR_W-1:0] rf_addr_d,
  output logic [DataWidth-1:0]  rf_d
);

  src_e                  grant_src;
  src_e                  wb_src;
  logic [REG_ADDR_W-1:0] grant_addr;
  logic [DataWidth-1:0]  grant_data;
  logic                  grant_wr;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  dbg_force;

  assign dbg_force = dbg_valid && (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    grant_src  = SRC_NONE;
    grant_addr = '0;
    grant_data = '0;
    if (dbg_force) begin
      grant_src  = SRC_DBG;
      grant_addr = dbg_addr;
      grant_data = dbg_data;
    end else if (mem_valid) begin
      grant_src  = SRC_MEM;
      grant_addr = mem_addr;
      grant_data = mem_data;
    end else if (alu_valid) begin
      grant_src  = SRC_ALU;
      grant_addr = alu_addr;
      grant_data = alu_data;
    end else if (dbg_valid) begin
      grant_src  = SRC_DBG;
      grant_addr = dbg_addr;
      grant_data = dbg_data;
    end
  end

  assign mem_ready = (grant_src == SRC_MEM);
  assign alu_ready = (grant_src == SRC_ALU);
  assign dbg_ready = (grant_src == SRC_DBG);

  // x0 writes are accepted and dropped here so they never reach the regfile or scoreboard.
  assign grant_wr = (grant_src != SRC_NONE) && (grant_addr != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wrd    <= 1'b0;
      rf_addr_d <= '0;
      rf_d      <= '0;
      wb_src    <= SRC_NONE;
    end else begin
      rf_wrd <= grant_wr;
      wb_src <= grant_wr ? grant_src : SRC_NONE;
      if (grant_wr) begin
        rf_addr_d <= grant_addr;
        rf_d      <= grant_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (dbg_ready) begin
      starve_cnt <= '0;
    end else if (dbg_valid && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Debug writes are side-band and must not retire an outstanding pipeline producer.
  regfile_scoreboard u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_vld  (iss_valid),
    .set_addr (iss_rd),
    .clr_vld  (rf_wrd && ((wb_src == SRC_MEM) || (wb_src == SRC_ALU))),
    .clr_addr (rf_addr_d),
    .flush    (flush),
    .chk_a    (chk_a),
    .chk_b    (chk_b),
    .chk_d    (chk_d),
    .busy_a   (busy_a),
    .busy_b   (busy_b),
    .busy_d   (busy_d)
  );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: arbitration table plus scoreboard/reset sequences.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, alu_valid, dbg_valid;
  logic        mem_ready, alu_ready, dbg_ready;
  logic [4:0]  mem_addr, alu_addr, dbg_addr;
  logic [31:0] mem_data, alu_data, dbg_data;
  logic        iss_valid, flush;
  logic [4:0]  iss_rd, chk_a, chk_b, chk_d;
  logic        busy_a, busy_b, busy_d;
  logic        rf_wrd;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign chk_d = iss_rd;

  regfile_wb_ctrl #(.DataWidth(32), .STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
    .chk_a(chk_a), .chk_b(chk_b), .chk_d(chk_d),
    .busy_a(busy_a), .busy_b(busy_b), .busy_d(busy_d),
    .rf_wrd(rf_wrd), .rf_addr_d(rf_addr_d), .rf_d(rf_d)
  );

  typedef struct {
    logic        mv; logic [4:0] ma; logic [31:0] md;
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        dv; logic [4:0] da; logic [31:0] dd;
    logic        emr; logic ear; logic edr;
    logic        ewrd; logic [4:0] eaddr; logic [31:0] edata;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    dbg_valid = 1'b0; dbg_addr = '0; dbg_data = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  // Issuing to a register that is still pending is an illegal decode action.
  always @(negedge clk) begin
    if (reset_n && iss_valid && (iss_rd != 5'd0) && busy_d) begin
      n_err++;
      $display("FAIL issue_to_busy: iss_rd=%0d busy_d=%0b, required 0", iss_rd, busy_d);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //            mem                 alu                 dbg                 ready  wr
    vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0,           1, 0, 0, 1, 5, 32'hDEADBEEF};
    vecs[1] = '{0, 0, 0,            0, 0, 0,           0, 0, 0,           0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 0, 0,            1, 10, 32'h11,     0, 0, 0,           0, 1, 0, 1, 10, 32'h11};
    vecs[3] = '{1, 1, 32'h22,       1, 2, 32'h44,      0, 0, 0,           1, 0, 0, 1, 1, 32'h22};
    vecs[4] = '{0, 0, 0,            1, 12, 32'h55,     1, 13, 32'h66,     0, 1, 0, 1, 12, 32'h55};
    vecs[5] = '{0, 0, 0,            0, 0, 0,           1, 2, 32'h33,      0, 0, 1, 1, 2, 32'h33};
    vecs[6] = '{0, 0, 0,            1, 0, 32'h77,      0, 0, 0,           0, 1, 0, 0, 0, 0};
    vecs[7] = '{1, 3, 32'h88,       1, 4, 32'h99,      1, 5, 32'hAA,      1, 0, 0, 1, 3, 32'h88};
    vecs[8] = '{0, 0, 0,            0, 0, 0,           1, 0, 32'hBB,      0, 0, 1, 0, 0, 0};

    idle_inputs();
    chk_a = 5'd7; chk_b = 5'd9;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_wrd", 32'(rf_wrd), 32'd0);
    check("reset_rf_addr_d", 32'(rf_addr_d), 32'd0);
    check("reset_rf_d", rf_d, 32'd0);
    check("reset_busy_a", 32'(busy_a), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      mem_valid = vecs[i].mv; mem_addr = vecs[i].ma; mem_data = vecs[i].md;
      alu_valid = vecs[i].av; alu_addr = vecs[i].aa; alu_data = vecs[i].ad;
      dbg_valid = vecs[i].dv; dbg_addr = vecs[i].da; dbg_data = vecs[i].dd;
      @(negedge clk);
      check($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].emr));
      check($sformatf("vec%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].ear));
      check($sformatf("vec%0d_dbg_ready", i), 32'(dbg_ready), 32'(vecs[i].edr));
      tick();
      check($sformatf("vec%0d_rf_wrd", i), 32'(rf_wrd), 32'(vecs[i].ewrd));
      if (vecs[i].ewrd) begin
        check($sformatf("vec%0d_rf_addr_d", i), 32'(rf_addr_d), 32'(vecs[i].eaddr));
        check($sformatf("vec%0d_rf_d", i), rf_d, vecs[i].edata);
      end
    end
    idle_inputs();
    tick();

    // Debug starvation: all three held high, debug forced through on the ninth cycle.
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'hA1;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'hA2;
    dbg_valid = 1'b1; dbg_addr = 5'd3; dbg_data = 32'hA3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("starve%0d_mem_ready", k), 32'(mem_ready), 32'(k != 9));
      check($sformatf("starve%0d_dbg_ready", k), 32'(dbg_ready), 32'(k == 9));
      check($sformatf("starve%0d_alu_ready", k), 32'(alu_ready), 32'd0);
      tick();
      if (k == 9) check("starve_dbg_rf_addr_d", 32'(rf_addr_d), 32'd3);
    end
    idle_inputs();
    tick();

    // Issue r7, ALU retires it; busy drops two cycles after the grant.
    chk_a = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    check("iss7_busy_a", 32'(busy_a), 32'd1);
    tick(); tick();
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h1234;
    @(negedge clk);
    check("alu7_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("alu7_rf_wrd", 32'(rf_wrd), 32'd1);
    check("alu7_rf_addr_d", 32'(rf_addr_d), 32'd7);
    check("alu7_busy_during_wb", 32'(busy_a), 32'd1);
    tick();
    check("alu7_busy_cleared", 32'(busy_a), 32'd0);
    check("alu7_rf_wrd_off", 32'(rf_wrd), 32'd0);

    // ALU commit to r3 and a new issue to r3 on the same edge: set wins.
    chk_a = 5'd3;
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h3333;
    tick();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd3;
    check("r3_rf_wrd", 32'(rf_wrd), 32'd1);
    tick();
    iss_valid = 1'b0;
    check("r3_set_wins", 32'(busy_a), 32'd1);

    // Flush overrides a same-edge issue and clears everything.
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd4;
    chk_a = 5'd4; chk_b = 5'd5;
    tick();
    flush = 1'b0; iss_valid = 1'b0;
    check("flush_busy_r4", 32'(busy_a), 32'd0);
    check("flush_busy_r5", 32'(busy_b), 32'd0);
    chk_b = 5'd3;
    #1;
    check("flush_busy_r3", 32'(busy_b), 32'd0);

    // x0 never becomes busy.
    chk_a = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    tick();
    iss_valid = 1'b0;
    check("x0_busy", 32'(busy_a), 32'd0);

    // Debug write to a busy r9 lands but leaves it busy; an x0 ALU write changes nothing.
    chk_a = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h9999;
    @(negedge clk);
    check("dbg9_ready", 32'(dbg_ready), 32'd1);
    tick();
    dbg_valid = 1'b0;
    check("dbg9_rf_wrd", 32'(rf_wrd), 32'd1);
    check("dbg9_rf_addr_d", 32'(rf_addr_d), 32'd9);
    check("dbg9_rf_d", rf_d, 32'h9999);
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h5A5A;
    @(negedge clk);
    check("alu_x0_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0;
    check("dbg9_busy_kept", 32'(busy_a), 32'd1);
    check("alu_x0_rf_wrd", 32'(rf_wrd), 32'd0);
    tick();
    check("alu_x0_busy_kept", 32'(busy_a), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Reset asserted while a registered write is in flight.
    chk_a = 5'd6;
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h6666;
    @(negedge clk);
    check("mem6_ready", 32'(mem_ready), 32'd1);
    tick();
    mem_valid = 1'b0;
    check("mem6_rf_wrd_before_reset", 32'(rf_wrd), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_rf_wrd", 32'(rf_wrd), 32'd0);
    check("arst_rf_addr_d", 32'(rf_addr_d), 32'd0);
    check("arst_rf_d", rf_d, 32'd0);
    check("arst_busy_r6", 32'(busy_a), 32'd0);
    tick();
    check("arst_rf_wrd_held", 32'(rf_wrd), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    tick();
    check("post_reset_rf_wrd", 32'(rf_wrd), 32'd0);
    check("post_reset_busy_r6", 32'(busy_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
